// File: rtl/spin_pkg.sv
// Shared constants and helpers for the spin-display timing blocks.
package spin_pkg;

  localparam int LINES_DEF   = 512;
  localparam int LINES_W_DEF = $clog2(LINES_DEF);
  localparam int CNT_W_DEF   = 24;

  // Line index seen by LED arm 'arm' when arm 0 is on line 'idx'.
  // Arms are evenly spread around the revolution; lines is a power of two.
  function automatic int unsigned arm_index(input int unsigned idx,
                                            input int unsigned arm,
                                            input int unsigned lines,
                                            input int unsigned arms);
    return (idx + arm * (lines / arms)) & (lines - 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser plus rising-edge detector for an asynchronous strobe.
// The rise pulse is registered, so an input high sampled at cycle 0 gives
// rise high at cycle SYNC_STAGES.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_prev;

  // Metastability chain, previous synchronised sample and registered edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      sync_prev  <= sync_chain[SYNC_STAGES-1];
      rise       <= sync_chain[SYNC_STAGES-1] & ~sync_prev;
    end
  end

endmodule

// File: rtl/line_sync_gen.sv
// Frame-to-line timing generator: measures the revolution period from
// frame_sync_in and spreads LINES evenly spaced line strobes over each frame.
module line_sync_gen
  import spin_pkg::*;
#(
  parameter int              LINES       = LINES_DEF,
  parameter int              CNT_W       = CNT_W_DEF,
  parameter int              SYNC_STAGES = 2,
  parameter int              MIN_PERIOD  = 4096,
  parameter longint unsigned TIMEOUT     = (64'd1 << CNT_W) - 64'd1,
  parameter int              LOCK_FRAMES = 2,
  parameter int              PULSE_W     = 4,
  parameter int              ARMS        = 1
) (
  input  logic                             sys_clk,
  input  logic                             global_rst,
  input  logic                             frame_sync_in,
  output logic                             line_sync,
  output logic [ARMS*$clog2(LINES)-1:0]    line_idx,
  output logic                             frame_start,
  output logic [CNT_W-1:0]                 frame_period,
  output logic                             locked
);

  localparam int LINES_W  = $clog2(LINES);
  localparam int LOCK_W   = $clog2(LOCK_FRAMES + 1);
  localparam int PULSE_CW = $clog2(PULSE_W + 1);

  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    MIN_V     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]    TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0]   LOCK_V    = LOCK_W'(LOCK_FRAMES);
  localparam logic [LINES_W-1:0]  IDX_MAX   = '1;
  localparam logic [CNT_W:0]      STEP      = (CNT_W+1)'(LINES);
  localparam logic [PULSE_CW-1:0] PULSE_V   = PULSE_CW'(PULSE_W);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LOCK_W-1:0] sat_inc_lock(input logic [LOCK_W-1:0] v);
    return (v >= LOCK_V) ? v : v + LOCK_W'(1);
  endfunction

  function automatic logic [PULSE_CW-1:0] dec_floor(input logic [PULSE_CW-1:0] v);
    return (v == '0) ? v : v - PULSE_CW'(1);
  endfunction

  logic                        rise;
  logic [CNT_W-1:0]            pcnt;
  logic [CNT_W-1:0]            pcnt_inc;
  logic [LOCK_W-1:0]           lock_cnt;
  logic [LOCK_W-1:0]           lock_inc;
  logic                        accept;
  logic                        timeout;
  logic                        lock_ok;
  logic [CNT_W:0]              acc;
  logic [CNT_W:0]              acc_sum;
  logic [CNT_W:0]              acc_nxt;
  logic signed [CNT_W+1:0]     acc_diff;
  logic                        step_hit;
  logic [LINES_W-1:0]          idx;
  logic [LINES_W-1:0]          idx_nxt;
  logic                        strobe;
  logic [PULSE_CW-1:0]         pulse_cnt;
  logic [PULSE_CW-1:0]         pulse_nxt;
  logic [ARMS*LINES_W-1:0]     idx_arms;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_edge (
    .clk      (sys_clk),
    .rst      (global_rst),
    .async_in (frame_sync_in),
    .rise     (rise)
  );

  // pcnt counts cycles already elapsed in the frame, so pcnt+1 is the
  // period in cycles measured on the cycle the edge arrives.
  assign pcnt_inc = sat_inc_cnt(pcnt);
  assign lock_inc = sat_inc_lock(lock_cnt);
  assign accept   = rise && (pcnt_inc >= MIN_V);
  assign timeout  = !accept && (pcnt_inc >= TIMEOUT_V);
  assign lock_ok  = locked || (lock_inc >= LOCK_V);

  // Period measurement, glitch rejection, lock qualification and timeout
  always_ff @(posedge sys_clk) begin
    if (global_rst) begin
      pcnt         <= '0;
      frame_period <= '0;
      lock_cnt     <= '0;
      locked       <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= accept;
      if (accept) begin
        pcnt         <= '0;
        frame_period <= pcnt_inc;
        lock_cnt     <= lock_inc;
        if (lock_ok) locked <= 1'b1;
      end else begin
        pcnt <= pcnt_inc;
        if (timeout) begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end

  // The accumulator gains LINES per cycle and sheds one frame_period per
  // line, so strobes land within one cycle of ideal and error never builds.
  assign acc_sum  = acc + STEP;
  assign acc_diff = signed'({1'b0, acc_sum}) - signed'({2'b00, frame_period});
  assign step_hit = (acc_diff >= 0);

  // Next accumulator/index and strobe decision; an accepted edge outranks overflow
  always_comb begin
    acc_nxt = acc;
    idx_nxt = idx;
    strobe  = 1'b0;
    if (timeout) begin
      acc_nxt = '0;
      idx_nxt = '0;
    end else if (accept && lock_ok) begin
      acc_nxt = '0;
      idx_nxt = '0;
      strobe  = 1'b1;
    end else if (locked && (idx != IDX_MAX)) begin
      if (step_hit) begin
        acc_nxt = acc_diff[CNT_W:0];
        idx_nxt = idx + LINES_W'(1);
        strobe  = 1'b1;
      end else begin
        acc_nxt = acc_sum;
      end
    end
  end

  // Accumulator and line index state
  always_ff @(posedge sys_clk) begin
    if (global_rst) begin
      acc <= '0;
      idx <= '0;
    end else begin
      acc <= acc_nxt;
      idx <= idx_nxt;
    end
  end

  // Per-arm line indices, arm 0 in the least significant field
  always_comb begin
    idx_arms = '0;
    for (int a = 0; a < ARMS; a++) begin
      idx_arms[a*LINES_W +: LINES_W] =
        LINES_W'(arm_index(32'(idx_nxt), a, LINES, ARMS));
    end
  end

  assign pulse_nxt = strobe ? PULSE_V : dec_floor(pulse_cnt);

  // Pulse stretcher; line_idx is loaded on the same edge that starts the pulse
  always_ff @(posedge sys_clk) begin
    if (global_rst || timeout) begin
      pulse_cnt <= '0;
      line_sync <= 1'b0;
      line_idx  <= '0;
    end else begin
      pulse_cnt <= pulse_nxt;
      line_sync <= (pulse_nxt != '0);
      if (strobe) line_idx <= idx_arms;
    end
  end

endmodule
